// File: rtl/line_clear_engine.sv
// line_clear_engine: sequences multi-row line clears after a piece lock.
// A snapshot of the full-row vector is held in a shadow register. One shift
// mask is issued per full row, top-most first. After each accepted shift the
// shadow is updated the same way the board moves, so that later row indices
// stay correct. A per-lock count and a saturating running total are kept.
module line_clear_engine #(
  parameter int ROWS  = 23,
  parameter int IDX_W = 5,
  parameter int CNT_W = 5,
  parameter int TOT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ROWS-1:0]  rowfull,
  input  logic             total_clr,
  output logic             shift_valid,
  input  logic             shift_ready,
  output logic [ROWS-1:0]  rowshift,
  output logic [IDX_W-1:0] shift_row,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lines_cleared,
  output logic [TOT_W-1:0] lines_total
);

  localparam int SUM_W = ((TOT_W > CNT_W) ? TOT_W : CNT_W) + 1;

  typedef enum logic [1:0] {IDLE, FIND, SHIFT, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [ROWS-1:0]   shadow;
  logic [ROWS-1:0]   shifted_shadow;
  logic [ROWS-1:0]   find_mask;
  logic              found;
  logic [IDX_W-1:0]  low_idx;
  logic [SUM_W-1:0]  sum_total;
  logic [SUM_W-1:0]  max_total;
  logic [TOT_W-1:0]  sat_total;

  // State register; reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: FIND and DONE last one cycle, SHIFT waits for ready.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FIND;
      FIND:    next_state = found ? SHIFT : DONE;
      SHIFT:   if (shift_ready) next_state = FIND;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    shift_valid = (state == SHIFT);
  end

  // Lowest set shadow bit is the top-most full row; also build its mask.
  always_comb begin
    found     = 1'b0;
    low_idx   = '0;
    find_mask = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (shadow[i]) begin
        found   = 1'b1;
        low_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < ROWS; i++) begin
      find_mask[i] = found && (IDX_W'(i) <= low_idx);
    end
  end

  // Shadow after clearing row shift_row: rows 0..k move down one, row 0 empties.
  always_comb begin
    shifted_shadow = shadow;
    for (int i = 0; i < ROWS; i++) begin
      if (IDX_W'(i) <= shift_row) begin
        shifted_shadow[i] = (i == 0) ? 1'b0 : shadow[(i == 0) ? 0 : i - 1];
      end
    end
  end

  // Saturating accumulate, done in a width wide enough for either operand.
  always_comb begin
    sum_total = SUM_W'(lines_total) + SUM_W'(lines_cleared);
    max_total = SUM_W'({TOT_W{1'b1}});
    sat_total = (sum_total > max_total) ? {TOT_W{1'b1}} : TOT_W'(sum_total);
  end

  // Datapath registers: snapshot, shift mask/index, per-lock count, total.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow        <= '0;
      rowshift      <= '0;
      shift_row     <= '0;
      lines_cleared <= '0;
      lines_total   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shadow        <= rowfull;
            lines_cleared <= '0;
          end
        end
        FIND: begin
          if (found) begin
            rowshift  <= find_mask;
            shift_row <= low_idx;
          end
        end
        SHIFT: begin
          if (shift_ready) begin
            shadow        <= shifted_shadow;
            lines_cleared <= lines_cleared + CNT_W'(1);
            rowshift      <= '0;
          end
        end
        default: ;
      endcase
      if (total_clr)
        lines_total <= '0;
      else if (state == DONE)
        lines_total <= sat_total;
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// tb_line_clear_engine: directed plus randomized line-clear sequences.
// The outputs are checked cycle by cycle against a reference model of the
// clearing rules. A second instance with TOT_W=2 shares the stimulus so that
// saturation of the running total is exercised.
module tb_line_clear_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [22:0] rowfull;
  logic        total_clr;
  logic        shift_ready;

  logic        shift_valid,  shift_valid2;
  logic [22:0] rowshift,     rowshift2;
  logic [4:0]  shift_row,    shift_row2;
  logic        busy,         busy2;
  logic        done,         done2;
  logic [4:0]  lines_cleared, lines_cleared2;
  logic [15:0] lines_total;
  logic [1:0]  lines_total2;

  int checks = 0;
  int passed = 0;
  int totModel = 0;
  int tot2Model = 0;

  line_clear_engine dut (
    .clk(clk), .rst(rst), .start(start), .rowfull(rowfull),
    .total_clr(total_clr), .shift_valid(shift_valid), .shift_ready(shift_ready),
    .rowshift(rowshift), .shift_row(shift_row), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .lines_total(lines_total)
  );

  line_clear_engine #(.TOT_W(2)) dutSat (
    .clk(clk), .rst(rst), .start(start), .rowfull(rowfull),
    .total_clr(total_clr), .shift_valid(shift_valid2), .shift_ready(shift_ready),
    .rowshift(rowshift2), .shift_row(shift_row2), .busy(busy2), .done(done2),
    .lines_cleared(lines_cleared2), .lines_total(lines_total2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full lock sequence; the model walks the clearing rules on its own copy.
  task automatic applyStimulus(input logic [22:0] v, input int firstStall, input bit clrAtDone);
    logic [22:0] sh;
    logic [31:0] mask;
    int k;
    int n;
    int stalls;
    start   = 1'b1;
    rowfull = v;
    tick();
    start   = 1'b0;
    rowfull = 23'($urandom);
    checkOutput("find_busy", busy, 1);
    checkOutput("find_valid", shift_valid, 0);
    checkOutput("find_cleared", lines_cleared, 0);
    checkOutput("find_done", done, 0);
    sh = v;
    n  = 0;
    while (sh != 0) begin
      k = 0;
      while (!sh[k]) k++;
      mask = (32'd1 << (k + 1)) - 32'd1;
      start   = 1'($urandom_range(0, 1));
      rowfull = 23'($urandom);
      tick();
      stalls = (n == 0 && firstStall >= 0) ? firstStall : $urandom_range(0, 2);
      for (int s = 0; s <= stalls; s++) begin
        checkOutput("shift_valid", shift_valid, 1);
        checkOutput("rowshift", rowshift, mask);
        checkOutput("shift_row", shift_row, k);
        checkOutput("rowshift_sat", rowshift2, mask);
        shift_ready = (s == stalls);
        start       = 1'($urandom_range(0, 1));
        tick();
      end
      shift_ready = 1'($urandom_range(0, 1));
      sh = (sh & ~mask[22:0]) | ((sh << 1) & mask[22:0]);
      n++;
      checkOutput("post_valid", shift_valid, 0);
      checkOutput("post_rowshift", rowshift, 0);
      checkOutput("post_cleared", lines_cleared, n);
      checkOutput("post_busy", busy, 1);
    end
    start = 1'b0;
    tick();
    checkOutput("done_pulse", done, 1);
    checkOutput("done_busy", busy, 1);
    checkOutput("done_cleared", lines_cleared, n);
    checkOutput("done_sat", done2, 1);
    checkOutput("done_cleared_sat", lines_cleared2, n);
    total_clr = clrAtDone;
    tick();
    total_clr = 1'b0;
    totModel  = clrAtDone ? 0 : ((totModel + n > 65535) ? 65535 : totModel + n);
    tot2Model = clrAtDone ? 0 : ((tot2Model + n > 3) ? 3 : tot2Model + n);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_cleared", lines_cleared, n);
    checkOutput("lines_total", lines_total, totModel);
    checkOutput("lines_total_sat", lines_total2, tot2Model);
  endtask

  initial begin
    logic [22:0] v;
    rst         = 1'b1;
    start       = 1'b0;
    rowfull     = '0;
    total_clr   = 1'b0;
    shift_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_valid", shift_valid, 0);
    checkOutput("rst_rowshift", rowshift, 0);
    checkOutput("rst_shift_row", shift_row, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cleared", lines_cleared, 0);
    checkOutput("rst_total", lines_total, 0);
    rst = 1'b0;
    tick();

    applyStimulus(23'h000000, -1, 1'b0);
    applyStimulus(23'h400000, 0, 1'b0);
    applyStimulus(23'h600000, 0, 1'b0);
    applyStimulus(23'h000408, 5, 1'b0);
    applyStimulus(23'h7FFFFF, -1, 1'b0);

    // Reset in the middle of a shift drops the shift and clears everything.
    start   = 1'b1;
    rowfull = 23'h000100;
    tick();
    start       = 1'b0;
    shift_ready = 1'b0;
    tick();
    checkOutput("pre_rst_valid", shift_valid, 1);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    totModel  = 0;
    tot2Model = 0;
    checkOutput("midrst_valid", shift_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_cleared", lines_cleared, 0);
    checkOutput("midrst_total", lines_total, 0);
    checkOutput("midrst_rowshift", rowshift, 0);

    // Three two-line sequences saturate the narrow total at 3.
    applyStimulus(23'h600000, -1, 1'b0);
    applyStimulus(23'h600000, -1, 1'b0);
    applyStimulus(23'h600000, -1, 1'b0);
    applyStimulus(23'h000020, -1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      v = 23'($urandom) & 23'($urandom);
      if (t % 7 == 3) v = v | 23'($urandom);
      applyStimulus(v, -1, ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
